// File: rtl/bram_axil_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bram_axil_arb : AXI4-Lite slave over a single-port BRAM, R/W arbitrated   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module bram_axil_arb #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 12,
  parameter int DEPTH_WORDS  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_SIZE-1:0]    wdata,
  input  logic [DATA_SIZE/8-1:0]  wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDRESS_SIZE-1:0] araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_SIZE-1:0]    rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_SIZE / 8;
  localparam int OFFS_W = $clog2(STRB_W);
  localparam int IDX_W  = ADDRESS_SIZE - OFFS_W;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH_WORDS);

  localparam logic [1:0] W_ADDR_DATA = 2'd0;
  localparam logic [1:0] W_MEM       = 2'd1;
  localparam logic [1:0] W_RESP      = 2'd2;
  localparam logic [1:0] R_ADDR      = 2'd0;
  localparam logic [1:0] R_MEM       = 2'd1;
  localparam logic [1:0] R_DATA      = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_SIZE-1:0] mem [DEPTH_WORDS];

  logic                 rdy_en_q,  rdy_en_d;
  logic [1:0]           w_state_q, w_state_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q,  w_done_d;
  logic [IDX_W-1:0]     w_idx_q,   w_idx_d;
  logic [DATA_SIZE-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0]    wstrb_q,   wstrb_d;
  logic [1:0]           bresp_q,   bresp_d;
  logic [1:0]           r_state_q, r_state_d;
  logic [IDX_W-1:0]     r_idx_q,   r_idx_d;
  logic [DATA_SIZE-1:0] rdata_q,   rdata_d;
  logic [1:0]           rresp_q,   rresp_d;
  logic                 last_wr_q, last_wr_d;

  logic                 wr_req, rd_req, wr_grant, rd_grant;
  logic                 w_in_range, r_in_range;
  logic [DATA_SIZE-1:0] rd_word;
  logic                 addr_lsb_unused;

  // Sub-word address bits select nothing and are deliberately dropped.
  assign addr_lsb_unused = ^{awaddr[OFFS_W-1:0], araddr[OFFS_W-1:0]};

  assign awready = rdy_en_q && (w_state_q == W_ADDR_DATA) && !aw_done_q;
  assign wready  = rdy_en_q && (w_state_q == W_ADDR_DATA) && !w_done_q;
  assign arready = rdy_en_q && (r_state_q == R_ADDR);
  assign bvalid  = (w_state_q == W_RESP);
  assign rvalid  = (r_state_q == R_DATA);
  assign bresp   = bresp_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign w_in_range = ({1'b0, w_idx_q} < DEPTH_L);
  assign r_in_range = ({1'b0, r_idx_q} < DEPTH_L);
  assign rd_word    = mem[r_idx_q[MEM_AW-1:0]];

  // On a tie the side that did not win last time gets the port.
  assign wr_req   = (w_state_q == W_MEM);
  assign rd_req   = (r_state_q == R_MEM);
  assign wr_grant = wr_req && (!rd_req || !last_wr_q);
  assign rd_grant = rd_req && !wr_grant;

  always_comb begin
    rdy_en_d  = 1'b1;
    last_wr_d = last_wr_q;
    if (wr_grant)      last_wr_d = 1'b1;
    else if (rd_grant) last_wr_d = 1'b0;
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    w_idx_d   = w_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_ADDR_DATA: begin
        if (awvalid && awready) begin
          w_idx_d   = awaddr[ADDRESS_SIZE-1:OFFS_W];
          aw_done_d = 1'b1;
        end
        if (wvalid && wready) begin
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          w_state_d = W_MEM;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_MEM: begin
        if (wr_grant) begin
          w_state_d = W_RESP;
          bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP:  if (bready) w_state_d = W_ADDR_DATA;
      default: w_state_d = W_ADDR_DATA;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_ADDR: begin
        if (arvalid && arready) begin
          r_idx_d   = araddr[ADDRESS_SIZE-1:OFFS_W];
          r_state_d = R_MEM;
        end
      end
      R_MEM: begin
        if (rd_grant) begin
          r_state_d = R_DATA;
          rdata_d   = r_in_range ? rd_word : '0;
          rresp_d   = r_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA:  if (rready) r_state_d = R_ADDR;
      default: r_state_d = R_ADDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en_q  <= 1'b0;
      w_state_q <= W_ADDR_DATA;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      w_idx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_ADDR;
      r_idx_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      last_wr_q <= 1'b1;
    end else begin
      rdy_en_q  <= rdy_en_d;
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      w_idx_q   <= w_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Storage is never reset; an aborted write never reaches here because
  // reset forces the write FSM out of W_MEM before the next edge.
  always_ff @(posedge clk) begin
    if (wr_grant && w_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) mem[w_idx_q[MEM_AW-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_axil_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bram_axil_arb : directed bench with a transaction-level reference      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_bram_axil_arb;

  localparam int DEPTH = 16;

  logic        clk, reset;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bram_axil_arb #(.DATA_SIZE(32), .ADDRESS_SIZE(12), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within budget, expected one (cycle %0d)", name, cyc);
  endtask

  // Reference: memory as a word array, channels as outstanding flags, the
  // shared port granted to a single requester or opposite to the last winner.
  logic [31:0] m_mem [DEPTH];
  logic [11:0] m_wa, m_ra;
  logic [31:0] m_wd, m_rdata;
  logic [3:0]  m_ws;
  logic [1:0]  m_bresp, m_rresp;
  bit m_en, m_aw_got, m_w_got, m_wr_pend, m_b_out, m_rd_pend, m_r_out, m_last_wr;
  bit e_aw, e_w, e_ar, g_rd, g_wr;
  int word;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}, 64'd0);
      m_en = 0; m_aw_got = 0; m_w_got = 0; m_wr_pend = 0;
      m_b_out = 0; m_rd_pend = 0; m_r_out = 0; m_last_wr = 1;
    end else begin
      e_aw = m_en && !m_aw_got && !m_wr_pend && !m_b_out;
      e_w  = m_en && !m_w_got  && !m_wr_pend && !m_b_out;
      e_ar = m_en && !m_rd_pend && !m_r_out;
      chk("awready", awready, e_aw);
      chk("wready",  wready,  e_w);
      chk("arready", arready, e_ar);
      chk("bvalid",  bvalid,  m_b_out);
      chk("rvalid",  rvalid,  m_r_out);
      if (m_b_out) chk("bresp", bresp, m_bresp);
      if (m_r_out) begin
        chk("rdata", rdata, m_rdata);
        chk("rresp", rresp, m_rresp);
      end
      if (m_b_out && bready) m_b_out = 0;
      if (m_r_out && rready) m_r_out = 0;
      g_rd = m_rd_pend && (!m_wr_pend || m_last_wr);
      g_wr = m_wr_pend && !g_rd;
      if (g_rd) begin
        word = int'(m_ra) / 4;
        if (word < DEPTH) begin
          m_rdata = m_mem[word[3:0]];
          m_rresp = 2'b00;
        end else begin
          m_rdata = 32'd0;
          m_rresp = 2'b10;
        end
        m_r_out = 1; m_rd_pend = 0; m_last_wr = 0;
      end
      if (g_wr) begin
        word = int'(m_wa) / 4;
        if (word < DEPTH) begin
          for (int b = 0; b < 4; b++)
            if (m_ws[b]) m_mem[word[3:0]][8*b +: 8] = m_wd[8*b +: 8];
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
        m_b_out = 1; m_wr_pend = 0; m_last_wr = 1;
      end
      if (arvalid && e_ar) begin m_ra = araddr; m_rd_pend = 1; end
      if (awvalid && e_aw) begin m_wa = awaddr; m_aw_got = 1; end
      if (wvalid && e_w) begin m_wd = wdata; m_ws = wstrb; m_w_got = 1; end
      if (m_aw_got && m_w_got) begin m_wr_pend = 1; m_aw_got = 0; m_w_got = 0; end
      m_en = 1;
    end
  end

  // Tasks start and end 1 time unit after a rising edge.
  task automatic write_txn(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [1:0] resp);
    int hs_edge, n;
    bit aw_ok, w_ok, got_b;
    aw_ok = 0; w_ok = 0; got_b = 0; hs_edge = 0; lat = -1; resp = 2'b11;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      @(negedge clk);
      if (awvalid && awready) begin aw_ok = 1; hs_edge = cyc + 1; end
      if (wvalid && wready)   begin w_ok = 1;  hs_edge = cyc + 1; end
      @(posedge clk); #1;
      if (aw_ok) awvalid = 0;
      if (w_ok)  wvalid = 0;
      n++;
    end
    if (!(aw_ok && w_ok)) timeout("aw_w_handshake");
    n = 0;
    while (!got_b && n < 20) begin
      @(negedge clk);
      if (bvalid) begin got_b = 1; lat = cyc + 1 - hs_edge; resp = bresp; end
      @(posedge clk); #1;
      n++;
    end
    if (!got_b) timeout("b_handshake");
    awvalid = 0; wvalid = 0; bready = 0;
  endtask

  task automatic read_txn(input logic [11:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    int hs_edge, n;
    bit ar_ok, got_r;
    ar_ok = 0; got_r = 0; hs_edge = 0; lat = -1; resp = 2'b11; d = 32'hFFFF_FFFF;
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    while (!ar_ok && n < 20) begin
      @(negedge clk);
      if (arready) begin ar_ok = 1; hs_edge = cyc + 1; end
      @(posedge clk); #1;
      if (ar_ok) arvalid = 0;
      n++;
    end
    if (!ar_ok) timeout("ar_handshake");
    n = 0;
    while (!got_r && n < 20) begin
      @(negedge clk);
      if (rvalid) begin got_r = 1; lat = cyc + 1 - hs_edge; d = rdata; resp = rresp; end
      @(posedge clk); #1;
      n++;
    end
    if (!got_r) timeout("r_handshake");
    arvalid = 0; rready = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
  endtask

  int          lat, hs, rv_e, bv_e;
  logic [31:0] data;
  logic [1:0]  resp, bresp_s, rresp_s;

  initial begin
    reset = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arvalid = 0; rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_readies", {awready, wready, arready}, 3'b000);
    chk("reset_valids", {bvalid, rvalid}, 2'b00);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("ready_before_first_edge", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    chk("ready_after_first_edge", {awready, wready, arready}, 3'b111);

    write_txn(12'h004, 32'hDEADBEEF, 4'hF, lat, resp);
    chk("w004_bresp", resp, 2'b00);
    chk("w004_latency", lat, 2);
    read_txn(12'h004, data, resp, lat);
    chk("r004_data", data, 32'hDEADBEEF);
    chk("r004_rresp", resp, 2'b00);
    chk("r004_latency", lat, 2);

    write_txn(12'h008, 32'hDEADBEEF, 4'hF, lat, resp);
    write_txn(12'h008, 32'h000000AA, 4'h1, lat, resp);
    read_txn(12'h008, data, resp, lat);
    chk("byte_lane_merge", data, 32'hDEADBEAA);

    write_txn(12'h004, 32'hFFFFFFFF, 4'h0, lat, resp);
    chk("zero_strb_bresp", resp, 2'b00);
    read_txn(12'h007, data, resp, lat);
    chk("zero_strb_unchanged_lsb_ignored", data, 32'hDEADBEEF);

    // W arrives three cycles ahead of AW
    wdata = 32'h12345678; wstrb = 4'hF; awaddr = 12'h00C; wvalid = 1; bready = 1;
    @(negedge clk);
    chk("early_w_wready", wready, 1'b1);
    @(posedge clk); #1;
    wvalid = 0;
    @(negedge clk);
    chk("wready_drops_after_capture", wready, 1'b0);
    chk("awready_still_open", awready, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    awvalid = 1;
    @(negedge clk);
    chk("late_aw_awready", awready, 1'b1);
    hs = cyc + 1;
    @(posedge clk); #1;
    awvalid = 0;
    bv_e = 0; bresp_s = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bvalid && bv_e == 0) begin bv_e = cyc + 1; bresp_s = bresp; end
    end
    @(posedge clk); #1;
    bready = 0;
    chk("late_aw_b_latency", bv_e - hs, 2);
    chk("late_aw_bresp", bresp_s, 2'b00);
    read_txn(12'h00C, data, resp, lat);
    chk("late_aw_data", data, 32'h12345678);

    // Out-of-range accesses (word 16 with 16 words)
    write_txn(12'h000, 32'h0BADF00D, 4'hF, lat, resp);
    write_txn(12'h040, 32'h12345678, 4'hF, lat, resp);
    chk("oor_bresp", resp, 2'b10);
    chk("oor_write_latency", lat, 2);
    read_txn(12'h040, data, resp, lat);
    chk("oor_rdata", data, 32'h0);
    chk("oor_rresp", resp, 2'b10);
    chk("oor_read_latency", lat, 2);
    read_txn(12'h000, data, resp, lat);
    chk("word0_unchanged", data, 32'h0BADF00D);

    // Simultaneous write and read right after reset: read wins the tie
    do_reset();
    awaddr = 12'h010; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 12'h004;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    @(negedge clk);
    chk("tie_readies", {awready, wready, arready}, 3'b111);
    hs = cyc + 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    rv_e = 0; bv_e = 0; data = 32'hFFFF_FFFF; bresp_s = 2'b11; rresp_s = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid && rv_e == 0) begin rv_e = cyc + 1; data = rdata; rresp_s = rresp; end
      if (bvalid && bv_e == 0) begin bv_e = cyc + 1; bresp_s = bresp; end
    end
    @(posedge clk); #1;
    bready = 0; rready = 0;
    chk("tie_read_latency", rv_e - hs, 2);
    chk("tie_write_latency", bv_e - hs, 3);
    chk("tie_rdata", data, 32'hDEADBEEF);
    chk("tie_rresp", rresp_s, 2'b00);
    chk("tie_bresp", bresp_s, 2'b00);
    read_txn(12'h010, data, resp, lat);
    chk("tie_write_landed", data, 32'hCAFEF00D);

    // Reset while in W_MEM drops the pending write
    write_txn(12'h018, 32'h11111111, 4'hF, lat, resp);
    awaddr = 12'h018; wdata = 32'h22222222; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    chk("drop_handshake", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0; bready = 0;
    @(posedge clk); #1;
    read_txn(12'h018, data, resp, lat);
    chk("aborted_write_dropped", data, 32'h11111111);

    // Stalled B channel, then reset during W_RESP
    awaddr = 12'h014; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    chk("stall_handshake", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    repeat (6) begin @(posedge clk); #1; end
    chk("bvalid_held", bvalid, 1'b1);
    reset = 1;
    #1;
    chk("bvalid_drops_on_reset", bvalid, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("ready_low_until_edge", {awready, wready}, 2'b00);
    @(posedge clk); #1;
    chk("ready_after_reset", {awready, wready}, 2'b11);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/bram_axil_arb.md
BRAM_AXIL_ARB -- requirements
Module: bram_axil_arb

Interface
REQ-001 Parameter DATA_SIZE, default 32, is the data bus width in bits; legal values are 32 and 64.
REQ-002 Parameter ADDRESS_SIZE, default 12, is the byte-address width.
REQ-003 Parameter DEPTH_WORDS, default 1024, is the number of memory words; it SHALL be at most 2^(ADDRESS_SIZE-log2(DATA_SIZE/8)).
REQ-004 Ports (name  direction  width  meaning):
  clk      in   1               single clock, rising edge
  reset    in   1               asynchronous, active-high reset
  awaddr   in   ADDRESS_SIZE    write byte address
  awvalid  in   1               write address valid
  awready  out  1               write address accepted
  wdata    in   DATA_SIZE       write data
  wstrb    in   DATA_SIZE/8     byte-lane enables
  wvalid   in   1               write data valid
  wready   out  1               write data accepted
  bresp    out  2               write response
  bvalid   out  1               write response valid
  bready   in   1               write response taken
  araddr   in   ADDRESS_SIZE    read byte address
  arvalid  in   1               read address valid
  arready  out  1               read address accepted
  rdata    out  DATA_SIZE       read data
  rresp    out  2               read response
  rvalid   out  1               read data valid
  rready   in   1               read data taken

Function
REQ-005 Word index SHALL be addr >> log2(DATA_SIZE/8); low address bits SHALL be ignored, not faulted.
REQ-006 The memory SHALL be single-port: at most one read or one write access per cycle.
REQ-007 Write FSM states SHALL be W_ADDR_DATA, W_MEM and W_RESP.
REQ-008 In W_ADDR_DATA, awready SHALL be 1 until the AW handshake and wready SHALL be 1 until the W handshake.
  - AW and W SHALL be accepted in either order or in the same cycle.
  - Each SHALL be deasserted after its own capture.
  - The FSM SHALL go to W_MEM once both are captured.
REQ-009 In W_MEM, the write SHALL occur in the first cycle the arbiter grants write.
  - Only bytes with wstrb[i]=1 SHALL be updated.
  - wstrb=0 SHALL leave memory unchanged and still respond OKAY.
  - The next state is W_RESP.
REQ-010 In W_RESP, bvalid SHALL be 1 and held with a stable bresp until bready=1; the FSM then returns to W_ADDR_DATA.
REQ-011 Read FSM states SHALL be R_ADDR, R_MEM and R_DATA.
  - arready SHALL be 1 only in R_ADDR.
  - In R_MEM, the memory SHALL be read in the granted cycle.
  - In R_DATA, rvalid=1 and rdata/rresp SHALL be held stable until rready=1, then return to R_ADDR.
REQ-012 Minimum latency:
  - Read: AR handshake at edge N, memory access at N+1, rvalid from N+2.
  - Write: last of AW/W at N, memory write at N+1, bvalid from N+2.
REQ-013 Arbiter: a single request SHALL be granted immediately.
  - Simultaneous read and write requests SHALL be granted alternately, opposite to the last grant.
  - last_grant SHALL reset to write, so read wins the first tie.
REQ-014 A word index >= DEPTH_WORDS SHALL be out of range.
  - Out-of-range writes SHALL perform no memory write and respond bresp=2'b10 (SLVERR).
  - Out-of-range reads SHALL respond rdata=0, rresp=2'b10.
  - Out-of-range transactions SHALL still pass through the arbiter and keep the normal latency.
REQ-015 In-range responses SHALL be 2'b00 (OKAY).
REQ-016 A write followed by a read of the same word, with the read granted after the write, SHALL return the new data; there is no read-around-write hazard.
REQ-017 Each channel SHALL carry at most one outstanding transaction; no new AR is accepted until the R handshake completes, and no new AW/W until the B handshake completes.

Reset
REQ-018 While reset=1, all FSMs SHALL enter idle states asynchronously and all outputs SHALL be 0 (awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata).
REQ-019 Ready signals SHALL rise on the first clock edge after reset deasserts.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 Reset asserted mid-transaction SHALL abort the transaction.
  - No response SHALL be issued for it.
  - A memory write not yet performed SHALL be dropped.

Verification
REQ-022 Write 0xDEADBEEF to 0x004 with wstrb=4'hF, then read 0x004 -> bresp=00, rdata=0xDEADBEEF, rresp=00, rvalid at N+2.
REQ-023 Write 0xDEADBEEF to 0x008, then write 0x000000AA to 0x008 with wstrb=4'h1, then read -> 0xDEADBEAA.
REQ-024 W presented 3 cycles before AW -> wready drops after W capture; bvalid 2 cycles after AW handshake; data correct.
REQ-025 AW/W and AR issued in the same cycle to different words after reset -> read granted first, write one cycle later; both complete with OKAY.
REQ-026 DEPTH_WORDS=16, write and read to 0x040 -> bresp=10, rresp=10, rdata=0; word 0 unchanged.
REQ-027 Hold bready=0 for 5 cycles, then assert reset during W_RESP -> bvalid drops immediately; after release, awready=wready=1.
